// File: rtl/id_stage_if.sv
// id_stage_if: fetch, register-file, writeback and execute signals of id_stage.
interface id_stage_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [WIDTH-1:0] in_pc;
    logic [ADDR-1:0]  rf_rs1;
    logic [ADDR-1:0]  rf_rs2;
    logic [WIDTH-1:0] rf_rdata1;
    logic [WIDTH-1:0] rf_rdata2;
    logic             wb_en;
    logic [ADDR-1:0]  wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_op1;
    logic [WIDTH-1:0] out_op2;
    logic [WIDTH-1:0] out_imm;
    logic [ADDR-1:0]  out_rd;
    logic             out_rd_wen;
    logic [6:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic             out_funct7b5;
    modport master (
        output in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data, flush, out_ready,
        input  in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_op1, out_op2, out_imm, out_rd,
               out_rd_wen, out_opcode, out_funct3, out_funct7b5
    );
    modport slave (
        input  in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data, flush, out_ready,
        output in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_op1, out_op2, out_imm, out_rd,
               out_rd_wen, out_opcode, out_funct3, out_funct7b5
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32 decode stage with operand read, busy scoreboard and hazard stall.
// Define ID_STAGE_WB_FWD_EN to forward same-cycle writeback data into the decoded operands.
module id_stage #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    localparam int NREG = 2 ** ADDR;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic             r_d_valid;
    logic [31:0]      r_d_instr;
    logic [WIDTH-1:0] r_d_pc;
    logic             r_e_valid;
    logic [WIDTH-1:0] r_e_pc, r_e_op1, r_e_op2, r_e_imm;
    logic [ADDR-1:0]  r_e_rd;
    logic             r_e_rd_wen;
    logic [6:0]       r_e_opcode;
    logic [2:0]       r_e_funct3;
    logic             r_e_funct7b5;
    logic [NREG-1:0]  r_busy;

    logic [6:0]       w_opc;
    logic [ADDR-1:0]  w_rs1, w_rs2, w_rd;
    logic             w_use1, w_use2, w_wen, w_fwd1, w_fwd2, w_haz, w_adv, w_in_fire, w_out_fire;
    logic [31:0]      w_imm32;
    logic [NREG-1:0]  w_set, w_clr;

    assign w_opc = r_d_instr[6:0];
    assign w_rs1 = ADDR'(r_d_instr[19:15]);
    assign w_rs2 = ADDR'(r_d_instr[24:20]);
    assign w_rd  = ADDR'(r_d_instr[11:7]);
    assign w_use1 = w_opc inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP};
    assign w_use2 = w_opc inside {OP_BR, OP_ST, OP_OP};
    assign w_wen  = w_opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM, OP_LD};

`ifdef ID_STAGE_WB_FWD_EN
    assign w_fwd1 = bus.wb_en && bus.wb_rd == w_rs1 && w_rs1 != '0;
    assign w_fwd2 = bus.wb_en && bus.wb_rd == w_rs2 && w_rs2 != '0;
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // An in-flight writer in E has not yet set its busy bit, so it is matched directly.
    assign w_haz = (w_use1 && w_rs1 != '0 && ((r_busy[w_rs1] && !w_fwd1) ||
                    (r_e_valid && r_e_rd_wen && r_e_rd == w_rs1))) ||
                   (w_use2 && w_rs2 != '0 && ((r_busy[w_rs2] && !w_fwd2) ||
                    (r_e_valid && r_e_rd_wen && r_e_rd == w_rs2))) ||
                   (w_wen && w_rd != '0 && (r_busy[w_rd] ||
                    (r_e_valid && r_e_rd_wen && r_e_rd == w_rd)));
    assign w_adv      = r_d_valid && !w_haz && (!r_e_valid || bus.out_ready);
    assign w_out_fire = r_e_valid && bus.out_ready;
    assign w_in_fire  = bus.in_valid && bus.in_ready;

    assign w_imm32 = (w_opc inside {OP_IMM, OP_LD, OP_JALR}) ? {{20{r_d_instr[31]}}, r_d_instr[31:20]} :
                     (w_opc == OP_ST) ? {{20{r_d_instr[31]}}, r_d_instr[31:25], r_d_instr[11:7]} :
                     (w_opc == OP_BR) ? {{19{r_d_instr[31]}}, r_d_instr[31], r_d_instr[7],
                                         r_d_instr[30:25], r_d_instr[11:8], 1'b0} :
                     (w_opc inside {OP_LUI, OP_AUIPC}) ? {r_d_instr[31:12], 12'b0} :
                     (w_opc == OP_JAL) ? {{11{r_d_instr[31]}}, r_d_instr[31], r_d_instr[19:12],
                                          r_d_instr[20], r_d_instr[30:21], 1'b0} : '0;

    // A flushed E never retires, so it cannot mark its destination busy.
    assign w_set = (w_out_fire && !bus.flush && r_e_rd_wen && r_e_rd != '0) ? ONE << r_e_rd : '0;
    assign w_clr = bus.wb_en ? ONE << bus.wb_rd : '0;

    assign bus.in_ready     = !r_d_valid || w_adv;
    assign bus.rf_rs1       = w_rs1;
    assign bus.rf_rs2       = w_rs2;
    assign bus.out_valid    = r_e_valid;
    assign bus.out_pc       = r_e_pc;
    assign bus.out_op1      = r_e_op1;
    assign bus.out_op2      = r_e_op2;
    assign bus.out_imm      = r_e_imm;
    assign bus.out_rd       = r_e_rd;
    assign bus.out_rd_wen   = r_e_rd_wen;
    assign bus.out_opcode   = r_e_opcode;
    assign bus.out_funct3   = r_e_funct3;
    assign bus.out_funct7b5 = r_e_funct7b5;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_valid <= 1'b0;
            r_d_instr <= '0;
            r_d_pc    <= '0;
        end else if (bus.flush) begin
            r_d_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_d_valid <= 1'b1;
            r_d_instr <= bus.in_instr;
            r_d_pc    <= bus.in_pc;
        end else if (w_adv) begin
            r_d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_valid    <= 1'b0;
            r_e_pc       <= '0;
            r_e_op1      <= '0;
            r_e_op2      <= '0;
            r_e_imm      <= '0;
            r_e_rd       <= '0;
            r_e_rd_wen   <= 1'b0;
            r_e_opcode   <= '0;
            r_e_funct3   <= '0;
            r_e_funct7b5 <= 1'b0;
        end else if (bus.flush) begin
            r_e_valid <= 1'b0;
        end else if (w_adv) begin
            r_e_valid    <= 1'b1;
            r_e_pc       <= r_d_pc;
            r_e_op1      <= w_fwd1 ? bus.wb_data : bus.rf_rdata1;
            r_e_op2      <= w_fwd2 ? bus.wb_data : bus.rf_rdata2;
            r_e_imm      <= WIDTH'($signed(w_imm32));
            r_e_rd       <= w_rd;
            r_e_rd_wen   <= w_wen;
            r_e_opcode   <= w_opc;
            r_e_funct3   <= r_d_instr[14:12];
            r_e_funct7b5 <= r_d_instr[30];
        end else if (w_out_fire) begin
            r_e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_busy <= '0;
        else       r_busy <= (r_busy & ~w_clr) | w_set;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage decode, stalls, backpressure, flush and reset.
module tb_id_stage;
    localparam logic [31:0] I_ADDI5 = 32'h0070_0293, I_ADD6 = 32'h0052_8333, I_BEQ = 32'hFE00_0CE3,
                            I_LUI7 = 32'h1234_53B7, I_JAL1 = 32'h0080_00EF, I_SW = 32'hFE51_2E23;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] regs [32] = '{default: 32'h0};

    id_stage_if #(.WIDTH(32), .ADDR(5)) bus ();
    id_stage #(.WIDTH(32), .ADDR(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rf_rdata1 = (bus.rf_rs1 == 5'd0) ? 32'h0 : regs[bus.rf_rs1];
    assign bus.rf_rdata2 = (bus.rf_rs2 == 5'd0) ? 32'h0 : regs[bus.rf_rs2];
    always @(posedge clk) if (bus.wb_en && bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_imm", bus.out_imm, 0);
        check("rst_out_rd", 32'(bus.out_rd), 0);
        check("rst_busy", dut.r_busy, 0);
        reset = 1'b0;

        present(I_ADDI5, 32'h100);
        tick();
        check("addi_c1_valid", 32'(bus.out_valid), 0);
        present(I_ADD6, 32'h104);
        #1 check("add_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("addi_c2_valid", 32'(bus.out_valid), 1);
        check("addi_imm", bus.out_imm, 7);
        check("addi_rd", 32'(bus.out_rd), 5);
        check("addi_wen", 32'(bus.out_rd_wen), 1);
        check("addi_pc", bus.out_pc, 32'h100);
        check("add_stall_ematch", 32'(bus.in_ready), 0);
        tick();
        check("addi_busy5", 32'(dut.r_busy[5]), 1);
        check("add_stall_valid", 32'(bus.out_valid), 0);
        check("add_stall_busy", 32'(bus.in_ready), 0);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'd7;
        #1;
`ifdef ID_STAGE_WB_FWD_EN
        check("add_fwd_ready", 32'(bus.in_ready), 1);
        tick();
        bus.wb_en = 1'b0;
`else
        check("add_wb_ready", 32'(bus.in_ready), 0);
        tick();
        bus.wb_en = 1'b0;
        check("add_wait_valid", 32'(bus.out_valid), 0);
        check("add_wait_ready", 32'(bus.in_ready), 1);
        tick();
`endif
        check("add_valid", 32'(bus.out_valid), 1);
        check("add_op1", bus.out_op1, 7);
        check("add_op2", bus.out_op2, 7);
        check("add_rd", 32'(bus.out_rd), 6);
        check("add_pc", bus.out_pc, 32'h104);
        tick();
        check("add_busy", dut.r_busy, 32'h40);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd6;
        tick();
        bus.wb_en = 1'b0;
        check("wb6_busy", dut.r_busy, 0);

        present(I_ADDI5, 32'h108);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("same_valid", 32'(bus.out_valid), 1);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'd7;
        tick();
        bus.wb_en = 1'b0;
        check("set_over_clr", dut.r_busy, 32'h20);
        bus.wb_en = 1'b1;
        tick();
        bus.wb_en = 1'b0;
        check("clr5_busy", dut.r_busy, 0);

        bus.out_ready = 1'b0;
        present(I_LUI7, 32'h200);
        tick();
        present(I_JAL1, 32'h204);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_pc", bus.out_pc, 32'h200);
            check("bp_imm", bus.out_imm, 32'h1234_5000);
            check("bp_ready", 32'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(bus.in_ready), 1);
        tick();
        check("jal_valid", 32'(bus.out_valid), 1);
        check("jal_pc", bus.out_pc, 32'h204);
        check("jal_imm", bus.out_imm, 8);
        check("jal_rd", 32'(bus.out_rd), 1);
        tick();
        check("bp_drain_valid", 32'(bus.out_valid), 0);
        check("bp_busy", dut.r_busy, 32'h82);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd7;
        tick();
        bus.wb_rd = 5'd1;
        tick();
        bus.wb_en = 1'b0;
        check("bp_clr_busy", dut.r_busy, 0);

        present(I_SW, 32'h300);
        tick();
        present(I_BEQ, 32'h304);
        tick();
        bus.in_valid = 1'b0;
        check("sw_valid", 32'(bus.out_valid), 1);
        check("sw_imm", bus.out_imm, 32'hFFFF_FFFC);
        check("sw_wen", 32'(bus.out_rd_wen), 0);
        check("sw_op2", bus.out_op2, 7);
        check("sw_funct3", 32'(bus.out_funct3), 2);
        check("sw_opcode", 32'(bus.out_opcode), 32'h23);
        check("beq_ready", 32'(bus.in_ready), 1);
        tick();
        check("beq_imm", bus.out_imm, 32'hFFFF_FFF8);
        check("beq_wen", 32'(bus.out_rd_wen), 0);
        check("beq_opcode", 32'(bus.out_opcode), 32'h63);
        check("beq_pc", bus.out_pc, 32'h304);
        tick();
        check("beq_drain", 32'(bus.out_valid), 0);
        check("beq_busy", dut.r_busy, 0);

        bus.out_ready = 1'b0;
        present(I_ADDI5, 32'h500);
        tick();
        present(I_BEQ, 32'h504);
        tick();
        present(I_LUI7, 32'h508);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_valid", 32'(bus.out_valid), 0);
        check("flush_ready", 32'(bus.in_ready), 1);
        check("flush_busy", dut.r_busy, 0);
        tick();
        check("flush_d_empty", 32'(bus.out_valid), 0);

        bus.out_ready = 1'b0;
        present(I_ADDI5, 32'h600);
        tick();
        present(I_JAL1, 32'h604);
        tick();
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        reset = 1'b1; bus.flush = 1'b1; bus.wb_en = 1'b1; bus.wb_rd = 5'd5;
        tick();
        reset = 1'b0; bus.flush = 1'b0; bus.wb_en = 1'b0; bus.in_valid = 1'b0;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_pc", bus.out_pc, 0);
        check("mid_rst_rd", 32'(bus.out_rd), 0);
        check("mid_rst_imm", bus.out_imm, 0);
        check("mid_rst_ready", 32'(bus.in_ready), 1);
        tick();
        check("mid_rst_d_empty", 32'(bus.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
